// File: rtl/clock_divider_multi_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master drives the controls and divisors, and the slave returns the per-channel outputs.
interface clock_divider_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WIDTH  = 28
);
  logic                      en;
  logic                      sync;
  logic [NUM_CH-1:0]         load;
  logic [NUM_CH*WIDTH-1:0]   div_in;
  logic [NUM_CH-1:0]         clock_out;
  logic [NUM_CH-1:0]         tick;
  logic [NUM_CH-1:0]         pending;

  modport master (
    output en, sync, load, div_in,
    input  clock_out, tick, pending
  );

  modport slave (
    input  en, sync, load, div_in,
    output clock_out, tick, pending
  );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with tick strobes.
// A new divisor takes effect only at a period boundary, so the output has no glitch. Sync restarts all channels at phase 0.
module clock_divider_multi #(
  parameter int unsigned      NUM_CH      = 2,
  parameter int unsigned      WIDTH       = 28,
  parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(20000000)
) (
  input logic                  clock_in,
  input logic                  reset,
  clock_divider_multi_if.slave bus
);

  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RST = (DIV_DEFAULT < DIV_MIN) ? DIV_MIN : DIV_DEFAULT;

  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] pend_vec;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic [WIDTH-1:0] div_in_c, load_val_c, cnt_inc_c;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap_c;

    assign div_in_c   = bus.div_in[ch*WIDTH +: WIDTH];
    assign load_val_c = (div_in_c < DIV_MIN) ? DIV_MIN : div_in_c;
    assign wrap_c     = (cnt_q == div_act_q - WIDTH'(1));
    assign cnt_inc_c  = wrap_c ? '0 : cnt_q + WIDTH'(1);

    // Next-state: sync beats en. A load that lands on a wrap edge bypasses the pending stage.
    always_comb begin
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      pend_d     = pend_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;
      if (bus.sync) begin
        cnt_d  = '0;
        clk_d  = 1'b1;
        pend_d = 1'b0;
        if (bus.load[ch]) begin
          div_act_d  = load_val_c;
          div_pend_d = load_val_c;
        end else if (pend_q) begin
          div_act_d = div_pend_q;
        end
      end else if (bus.en) begin
        cnt_d  = cnt_inc_c;
        tick_d = wrap_c;
        if (bus.load[ch]) begin
          div_pend_d = load_val_c;
          if (wrap_c) begin
            div_act_d = load_val_c;
            pend_d    = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end else if (wrap_c && pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
        clk_d = (cnt_d < (div_act_d >> 1));
      end else if (bus.load[ch]) begin
        div_pend_d = load_val_c;
        pend_d     = 1'b1;
      end
    end

    always_ff @(posedge clock_in) begin
      if (reset) begin
        cnt_q      <= '0;
        div_act_q  <= DIV_RST;
        div_pend_q <= DIV_RST;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        pend_q     <= pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_vec[ch]  = clk_q;
    assign tick_vec[ch] = tick_q;
    assign pend_vec[ch] = pend_q;
  end

  assign bus.clock_out = clk_vec;
  assign bus.tick      = tick_vec;
  assign bus.pending   = pend_vec;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Testbench for clock_divider_multi with two channels and DIV_DEFAULT=4.
// A table of per-cycle vectors is followed by bounded sequences for the divisor clamp and the period length.
module tb_clock_divider_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned WIDTH  = 28;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  clock_divider_multi_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  clock_divider_multi #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV_DEFAULT(28'd4)
  ) dut (
    .clock_in(clk),
    .reset   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        sync;
    logic [1:0]  load;
    logic [27:0] d0;
    logic [27:0] d1;
    logic [1:0]  clk;
    logic [1:0]  tick;
    logic [1:0]  pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic s, input logic [1:0] ld,
                     input int unsigned a, input int unsigned b,
                     input logic [1:0] c, input logic [1:0] t, input logic [1:0] p);
    vec_t v;
    v.rst = r; v.en = e; v.sync = s; v.load = ld;
    v.d0 = 28'(a); v.d1 = 28'(b);
    v.clk = c; v.tick = t; v.pend = p;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive the inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic e, input logic s, input logic [1:0] ld,
                       input logic [27:0] a, input logic [27:0] b);
    @(negedge clk);
    rst        = r;
    bus.en     = e;
    bus.sync   = s;
    bus.load   = ld;
    bus.div_in = {b, a};
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int gap;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.sync = 1'b0; bus.load = '0; bus.div_in = '0;

    // rst en sync load d0 d1 | clk tick pend   (bit1=ch1, bit0=ch0)
    add(1,0,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(1,0,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    // default divisor 4 on both channels
    add(0,1,0,2'b00,0,0, 2'b11,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b11,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b11,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b00,2'b00);
    // ch0 loads 8 mid-period, ch1 loads 1 (clamped to 2)
    add(0,1,0,2'b11,8,1, 2'b00,2'b00,2'b11);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b11);
    add(0,1,0,2'b00,0,0, 2'b11,2'b11,2'b00);
    add(0,1,0,2'b00,0,0, 2'b01,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b10,2'b00);
    add(0,1,0,2'b00,0,0, 2'b01,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b10,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b10,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b11,2'b00);
    // two loads (6 then 10) in one period: only 10 is used
    add(0,1,0,2'b01,6,0,  2'b01,2'b00,2'b01);
    add(0,1,0,2'b01,10,0, 2'b11,2'b10,2'b01);
    add(0,1,0,2'b00,0,0,  2'b01,2'b00,2'b01);
    add(0,1,0,2'b00,0,0,  2'b10,2'b10,2'b01);
    add(0,1,0,2'b00,0,0,  2'b00,2'b00,2'b01);
    add(0,1,0,2'b00,0,0,  2'b10,2'b10,2'b01);
    add(0,1,0,2'b00,0,0,  2'b00,2'b00,2'b01);
    add(0,1,0,2'b00,0,0,  2'b11,2'b11,2'b00);
    add(0,1,0,2'b00,0,0,  2'b01,2'b00,2'b00);
    add(0,1,0,2'b00,0,0,  2'b11,2'b10,2'b00);
    add(0,1,0,2'b00,0,0,  2'b01,2'b00,2'b00);
    add(0,1,0,2'b00,0,0,  2'b11,2'b10,2'b00);
    add(0,1,0,2'b00,0,0,  2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0,  2'b10,2'b10,2'b00);
    add(0,1,0,2'b00,0,0,  2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0,  2'b10,2'b10,2'b00);
    add(0,1,0,2'b00,0,0,  2'b00,2'b00,2'b00);
    // loads on a wrap edge for both channels: bypass (3 and 7)
    add(0,1,0,2'b11,3,7, 2'b11,2'b11,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b01,2'b01,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    // en low for 3 cycles, with a ch0 load of 4 while disabled
    add(0,0,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,0,0,2'b01,4,0, 2'b00,2'b00,2'b01);
    add(0,0,0,2'b00,0,0, 2'b00,2'b00,2'b01);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b01);
    add(0,1,0,2'b00,0,0, 2'b01,2'b01,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b10,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b00,2'b00);
    // sync with a ch0 load of 3 applied on the same edge
    add(0,1,1,2'b01,3,0, 2'b11,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b01,2'b01,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b01,2'b01,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b10,2'b00);
    // reset together with sync and load: the reset values take effect
    add(1,1,1,2'b11,9,9, 2'b00,2'b00,2'b00);
    // ch0 divisor 5: high 2 cycles, low 3 cycles
    add(0,1,0,2'b01,5,0, 2'b11,2'b00,2'b01);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b01);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b01);
    add(0,1,0,2'b00,0,0, 2'b11,2'b11,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b00,2'b00,2'b00);
    add(0,1,0,2'b00,0,0, 2'b10,2'b10,2'b00);
    add(0,1,0,2'b00,0,0, 2'b11,2'b01,2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].sync, vecs[i].load, vecs[i].d0, vecs[i].d1);
      check($sformatf("v%0d_clock_out", i), bus.clock_out, vecs[i].clk);
      check($sformatf("v%0d_tick", i),      bus.tick,      vecs[i].tick);
      check($sformatf("v%0d_pending", i),   bus.pending,   vecs[i].pend);
    end

    // ch0 divisor 0 is clamped to 2: wait for the boundary, then expect a toggle every cycle
    drive(0, 1, 0, 2'b01, 28'd0, 28'd0);
    check("clamp0_pending_set", {1'b0, bus.pending[0]}, 2'b01);
    n = 0;
    while (bus.pending[0] === 1'b1 && n < 20) begin
      drive(0, 1, 0, 2'b00, 28'd0, 28'd0);
      n++;
    end
    check("clamp0_pending_clear", {1'b0, bus.pending[0]}, 2'b00);
    check("clamp0_wrap_tick", {1'b0, bus.tick[0]}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 2'b00, 28'd0, 28'd0);
      check($sformatf("clamp0_clk_k%0d", k),  {1'b0, bus.clock_out[0]}, 2'((k % 2)));
      check($sformatf("clamp0_tick_k%0d", k), {1'b0, bus.tick[0]},      2'((k % 2)));
    end

    // ch1 keeps the default divisor 4, so its tick period must be 4 cycles
    n = 0;
    while (bus.tick[1] !== 1'b1 && n < 10) begin
      drive(0, 1, 0, 2'b00, 28'd0, 28'd0);
      n++;
    end
    gap = 0;
    do begin
      drive(0, 1, 0, 2'b00, 28'd0, 28'd0);
      gap++;
    end while (bus.tick[1] !== 1'b1 && gap < 10);
    check("ch1_tick_period", 2'(gap), 2'(4));
    tests++;
    if (gap != 4) begin
      fails++;
      $display("FAIL ch1_tick_period_full: got %0d expected 4", gap);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
